// File: rtl/chacha_qr_pkg.sv
// rtl/chacha_qr_pkg.sv - shared types and constants for the ChaCha quarter-round host
// Contents:
//   qr_state_e   host sequencer states
//   WORD_*       word select values for bus_addr[3:2]
//   BYTE_W       byte lane field width (bus_addr[1:0])
//   ADDR_W       full byte index width
//   NUM_BYTES    bytes per 128-bit state
//   ROUND_W      round count width
package chacha_qr_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_ROUND = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } qr_state_e;

  localparam int WORD_A    = 0;
  localparam int WORD_B    = 1;
  localparam int WORD_C    = 2;
  localparam int WORD_D    = 3;
  localparam int WORD_W    = 2;
  localparam int BYTE_W    = 2;
  localparam int ADDR_W    = WORD_W + BYTE_W;
  localparam int NUM_BYTES = 16;
  localparam int ROUND_W   = 8;

endpackage

// File: rtl/chacha_qr_host.sv
// rtl/chacha_qr_host.sv - byte-wide initiator driving a ChaCha quarter-round peripheral
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       input channel: in_a..in_d state words, in_rounds count
//   out_valid/out_ready     output channel: out_a..out_d result words
//   busy                    high whenever not idle
//   bus_addr/bus_wr_en/bus_qr_en/bus_wdata   registered peripheral strobes
//   bus_rdata               peripheral read byte, combinational from bus_addr
// Parameter RD_WAIT: extra cycles bus_addr is held before bus_rdata is sampled.
module chacha_qr_host
  import chacha_qr_pkg::*;
#(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  input  logic [7:0]  in_rounds,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        busy,
  output logic [3:0]  bus_addr,
  output logic        bus_wr_en,
  output logic        bus_qr_en,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  localparam int                WAIT_W    = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_BYTES - 1);

  qr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   idx_inc;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ROUND_W-1:0]  rnd_q, rnd_d;
  // Byte k of the state lives at bits [8k +: 8], so {d,c,b,a} packs
  // word (k>>2), lane (k&3) without any address arithmetic.
  logic [127:0]        st_q, st_d;
  logic [127:0]        res_q, res_d;
  logic [3:0]          addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                qr_q, qr_d;
  logic [7:0]          wdata_q, wdata_d;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    res_d   = res_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    qr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = {in_d, in_c, in_b, in_a};
          rnd_d   = in_rounds;
          idx_d   = '0;
          addr_d  = '0;
          wr_d    = 1'b1;
          wdata_d = in_a[7:0];
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_inc;
          addr_d  = idx_inc;
          wr_d    = 1'b1;
          wdata_d = st_q[{idx_inc, 3'b000} +: 8];
        end else if (rnd_q != '0) begin
          qr_d    = 1'b1;
          state_d = S_ROUND;
        end else begin
          idx_d   = '0;
          wait_d  = '0;
          addr_d  = '0;
          state_d = S_READ;
        end
      end

      // rnd_q counts the strobes still to be issued, including the current
      // one, so leaving at 1 never lets the counter pass through zero.
      S_ROUND: begin
        rnd_d = rnd_q - 1'b1;
        if (rnd_q == ROUND_W'(1)) begin
          idx_d   = '0;
          wait_d  = '0;
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          qr_d = 1'b1;
        end
      end

      S_READ: begin
        if (wait_q == WAIT_LAST) begin
          res_d[{idx_q, 3'b000} +: 8] = bus_rdata;
          wait_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_inc;
            addr_d = idx_inc;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      rnd_q   <= '0;
      st_q    <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      qr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      qr_q    <= qr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_a     = res_q[WORD_A*32 +: 32];
  assign out_b     = res_q[WORD_B*32 +: 32];
  assign out_c     = res_q[WORD_C*32 +: 32];
  assign out_d     = res_q[WORD_D*32 +: 32];
  assign bus_addr  = addr_q;
  assign bus_wr_en = wr_q;
  assign bus_qr_en = qr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_chacha_qr_host.sv
// tb/tb_chacha_qr_host.sv - self-checking bench for chacha_qr_host with behavioural QR peripherals
module tb_chacha_qr_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid0, in_valid2;
  logic [31:0] in_a, in_b, in_c, in_d;
  logic [7:0]  in_rounds;
  logic        out_ready;

  logic        in_ready0, out_valid0, busy0, wr0, qr0;
  logic [31:0] oa0, ob0, oc0, od0;
  logic [3:0]  addr0;
  logic [7:0]  wdata0, rdata0;

  logic        in_ready2, out_valid2, busy2, wr2, qr2;
  logic [31:0] oa2, ob2, oc2, od2;
  logic [3:0]  addr2;
  logic [7:0]  wdata2, rdata2;

  chacha_qr_host #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_rounds(in_rounds),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_a(oa0), .out_b(ob0), .out_c(oc0), .out_d(od0),
    .busy(busy0), .bus_addr(addr0), .bus_wr_en(wr0), .bus_qr_en(qr0),
    .bus_wdata(wdata0), .bus_rdata(rdata0)
  );

  chacha_qr_host #(.RD_WAIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_rounds(in_rounds),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_a(oa2), .out_b(ob2), .out_c(oc2), .out_d(od2),
    .busy(busy2), .bus_addr(addr2), .bus_wr_en(wr2), .bus_qr_en(qr2),
    .bus_wdata(wdata2), .bus_rdata(rdata2)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // One ChaCha quarter-round on {d,c,b,a}.
  function automatic logic [127:0] qr_step(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    a = s[31:0]; b = s[63:32]; c = s[95:64]; d = s[127:96];
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input int n);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = qr_step(r);
    return r;
  endfunction

  // Behavioural QR peripherals: 16 byte registers, write strobe, step strobe.
  logic [127:0] pm0, pm2;
  always @(posedge clk) begin
    if (!rst_n) pm0 <= '0;
    else if (wr0) pm0[{addr0, 3'b000} +: 8] <= wdata0;
    else if (qr0) pm0 <= qr_step(pm0);
  end
  always @(posedge clk) begin
    if (!rst_n) pm2 <= '0;
    else if (wr2) pm2[{addr2, 3'b000} +: 8] <= wdata2;
    else if (qr2) pm2 <= qr_step(pm2);
  end
  assign rdata0 = pm0[{addr0, 3'b000} +: 8];
  assign rdata2 = pm2[{addr2, 3'b000} +: 8];

  // Bus activity logs.
  logic [11:0] wlog0[$];
  logic [3:0]  rlog0[$];
  logic [3:0]  rlog2[$];
  int          qrc0 = 0, qrc2 = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (wr0) wlog0.push_back({addr0, wdata0});
    if (qr0) qrc0++;
    if (qr2) qrc2++;
    if (busy0 && !wr0 && !qr0 && !out_valid0) rlog0.push_back(addr0);
    if (busy2 && !wr2 && !qr2 && !out_valid2) rlog2.push_back(addr2);
    if ((wr0 && qr0) || (wr2 && qr2)) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int sel, input logic [31:0] a, b, c, d,
                         input logic [7:0] n, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_d = d; in_rounds = n;
    if (sel == 0) in_valid0 = 1'b1; else in_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid0 = 1'b0; in_valid2 = 1'b0;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((sel == 0) ? out_valid0 : out_valid2) break;
    end
  endtask

  task automatic accept(input int sel);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (sel == 0) chk("accept_ready0", {in_ready0, out_valid0}, 2'b10);
    else          chk("accept_ready2", {in_ready2, out_valid2}, 2'b10);
  endtask

  logic [127:0] rfc_in, rfc_out, sv, expv, snap;
  int lat, w0, r0, q0, bad, n;

  initial begin
    rfc_in  = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};
    rfc_out = {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4};
    rst_n = 1'b0; in_valid0 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_rounds = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values.
    chk("reset_ctl0", {in_ready0, out_valid0, busy0, addr0, wr0, qr0, wdata0}, {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0});
    chk("reset_out0", {od0, oc0, ob0, oa0}, 128'd0);
    chk("reset_ctl2", {in_ready2, out_valid2, busy2, addr2, wr2, qr2, wdata2}, {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0});

    // RFC vector, one quarter-round, with bus byte-order checks.
    chk("rfc_model", ref_model(rfc_in, 1), rfc_out);
    w0 = wlog0.size(); r0 = rlog0.size(); q0 = qrc0;
    run_txn(0, 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567, 8'd1, lat);
    chk("rfc_latency", lat, 33);
    chk("rfc_result", {od0, oc0, ob0, oa0}, rfc_out);
    chk("rfc_wr_count", wlog0.size() - w0, 16);
    chk("rfc_wr_addr4_7", {wlog0[w0+4], wlog0[w0+5], wlog0[w0+6], wlog0[w0+7]},
        {4'd4, 8'h04, 4'd5, 8'h03, 4'd6, 8'h02, 4'd7, 8'h01});
    chk("rfc_wr_addr12", wlog0[w0+12], {4'd12, 8'h67});
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (wlog0[w0+k] !== {4'(k), rfc_in[8*k +: 8]}) bad++;
    chk("rfc_wr_sequence", bad, 0);
    chk("rfc_qr_cycles", qrc0 - q0, 1);
    chk("rfc_rd_count", rlog0.size() - r0, 16);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (rlog0[r0+k] !== 4'(k)) bad++;
    chk("rfc_rd_order", bad, 0);
    accept(0);

    // Zero rounds: output equals input, no step strobes.
    q0 = qrc0;
    run_txn(0, 32'hdeadbeef, 32'h0, 32'hffffffff, 32'h00000001, 8'd0, lat);
    chk("zero_latency", lat, 32);
    chk("zero_result", {od0, oc0, ob0, oa0}, {32'h00000001, 32'hffffffff, 32'h0, 32'hdeadbeef});
    chk("zero_qr_cycles", qrc0 - q0, 0);
    accept(0);

    // Backpressure in DONE, with an ignored in_valid pulse.
    sv = {$urandom, $urandom, $urandom, $urandom};
    run_txn(0, sv[31:0], sv[63:32], sv[95:64], sv[127:96], 8'd3, lat);
    snap = {od0, oc0, ob0, oa0};
    chk("bp_result", snap, ref_model(sv, 3));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_a = 32'h12345678; in_rounds = 8'd5; in_valid0 = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid0 = 1'b0;
      if (!out_valid0 || in_ready0 || ({od0, oc0, ob0, oa0} !== snap)) bad++;
    end
    chk("bp_stable", bad, 0);
    accept(0);
    repeat (5) @(negedge clk);
    chk("bp_not_queued", {busy0, in_ready0}, 2'b01);
    chk("bp_result_retained", {od0, oc0, ob0, oa0}, snap);

    // Randomized transactions on both builds.
    for (int i = 0; i < 8; i++) begin
      sv = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(0, 24);
      if (i % 2 == 0) begin
        run_txn(0, sv[31:0], sv[63:32], sv[95:64], sv[127:96], 8'(n), lat);
        chk("rand_result0", {od0, oc0, ob0, oa0}, ref_model(sv, n));
        chk("rand_latency0", lat, 32 + n);
        accept(0);
      end else begin
        run_txn(2, sv[31:0], sv[63:32], sv[95:64], sv[127:96], 8'(n), lat);
        chk("rand_result2", {od2, oc2, ob2, oa2}, ref_model(sv, n));
        chk("rand_latency2", lat, 16 + n + 48);
        accept(2);
      end
    end

    // Maximum round count must not wrap.
    sv = {$urandom, $urandom, $urandom, $urandom};
    q0 = qrc0;
    run_txn(0, sv[31:0], sv[63:32], sv[95:64], sv[127:96], 8'd255, lat);
    chk("max_latency", lat, 287);
    chk("max_qr_cycles", qrc0 - q0, 255);
    chk("max_result", {od0, oc0, ob0, oa0}, ref_model(sv, 255));
    accept(0);

    // Reset mid-ROUND.
    @(negedge clk);
    in_a = 32'haaaa5555; in_b = 32'h1; in_c = 32'h2; in_d = 32'h3; in_rounds = 8'd200;
    in_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (48) @(posedge clk);
    @(negedge clk);
    chk("mid_round_busy", {busy0, qr0}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ctl", {in_ready0, out_valid0, busy0, addr0, wr0, qr0, wdata0}, {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0});
    chk("rst_out", {od0, oc0, ob0, oa0}, 128'd0);
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (out_valid0 || busy0) bad++;
    end
    chk("rst_discarded", bad, 0);
    run_txn(0, 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567, 8'd1, lat);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_result", {od0, oc0, ob0, oa0}, rfc_out);
    accept(0);

    // RD_WAIT=2 build on the RFC vector.
    r0 = rlog2.size();
    run_txn(2, 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567, 8'd1, lat);
    chk("rw2_latency", lat, 65);
    chk("rw2_result", {od2, oc2, ob2, oa2}, rfc_out);
    chk("rw2_rd_count", rlog2.size() - r0, 48);
    bad = 0;
    for (int k = 0; k < 48; k++)
      if (rlog2[r0+k] !== 4'(k / 3)) bad++;
    chk("rw2_rd_hold", bad, 0);
    accept(2);

    chk("wr_qr_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
